// File: rtl/rayforge_pkg.sv
// Shared fixed-point definitions for the rayforge pipeline stages.
package rayforge_pkg;

    localparam int Q_FRAC = 4;

    typedef enum logic [2:0] {
        IDLE,
        SUB,
        MAC,
        TCA,
        SQRT,
        ROOT,
        DONE
    } state_e;

    function automatic int max_q(input int w);
        return (1 <<< (w - 1)) - 1;
    endfunction

    function automatic int min_q(input int w);
        return -(1 <<< (w - 1));
    endfunction

    // Clamp a signed 32-bit value into the signed range of a w-bit word.
    function automatic logic signed [31:0] sat_to_width(input logic signed [31:0] x, input int w);
        if (x > max_q(w)) begin
            return max_q(w);
        end
        if (x < min_q(w)) begin
            return min_q(w);
        end
        return x;
    endfunction

endpackage

// File: rtl/seq_isqrt.sv
// Iterative restoring integer square root: 2*WIDTH-bit operand, WIDTH-bit root,
// one root bit per cycle, MSB first; the first iteration happens on the start edge.
module seq_isqrt #(
    parameter int WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2*WIDTH-1:0]   operand,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     root
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH+1:0]   r_rem;
    logic [WIDTH-1:0]   r_root;
    logic [2*WIDTH-1:0] r_op;
    logic [CW-1:0]      r_cnt;
    logic               r_busy;
    logic               r_done;

    logic [WIDTH+1:0]   w_rem_in;
    logic [WIDTH-1:0]   w_root_in;
    logic [2*WIDTH-1:0] w_op_in;
    logic [WIDTH+1:0]   w_rem_sh;
    logic [WIDTH+1:0]   w_trial;
    logic               w_ge;
    logic [WIDTH+1:0]   w_rem_nx;
    logic [WIDTH-1:0]   w_root_nx;
    logic [2*WIDTH-1:0] w_op_nx;

    assign w_rem_in  = start ? '0 : r_rem;
    assign w_root_in = start ? '0 : r_root;
    assign w_op_in   = start ? operand : r_op;

    // Before the shift the remainder never exceeds WIDTH bits, so the top bits can drop.
    assign w_rem_sh  = (WIDTH + 2)'({w_rem_in, w_op_in[2*WIDTH-1 -: 2]});
    assign w_trial   = {w_root_in, 2'b01};
    assign w_ge      = (w_rem_sh >= w_trial);
    assign w_rem_nx  = w_ge ? (w_rem_sh - w_trial) : w_rem_sh;
    assign w_root_nx = WIDTH'({w_root_in, w_ge});
    assign w_op_nx   = {w_op_in[2*WIDTH-3:0], 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem  <= '0;
            r_root <= '0;
            r_op   <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start || r_busy) begin
                r_rem  <= w_rem_nx;
                r_root <= w_root_nx;
                r_op   <= w_op_nx;
                if (start) begin
                    r_busy <= 1'b1;
                    r_cnt  <= CW'(WIDTH - 1);
                end else if (r_cnt == CW'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                    r_cnt  <= '0;
                end else begin
                    r_cnt <= r_cnt - CW'(1);
                end
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign root = r_root;

endmodule

// File: rtl/ray_sphere_intersect.sv
// Fixed-latency ray/sphere intersection on Q8.4 vectors: returns the nearest hit distance
// at or beyond T_MIN, or a miss with t = MAX_Q.
module ray_sphere_intersect
    import rayforge_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int T_MIN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] ox,
    input  logic [WIDTH-1:0] oy,
    input  logic [WIDTH-1:0] oz,
    input  logic [WIDTH-1:0] dx,
    input  logic [WIDTH-1:0] dy,
    input  logic [WIDTH-1:0] dz,
    input  logic [WIDTH-1:0] cx,
    input  logic [WIDTH-1:0] cy,
    input  logic [WIDTH-1:0] cz,
    input  logic [WIDTH-1:0] radius,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_hit,
    output logic [WIDTH-1:0] out_t
);

    localparam int LW = WIDTH + 1;
    localparam int AW = 2 * WIDTH + 4;
    localparam int HW = 2 * WIDTH + 8;
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0]        T_MISS = WIDTH'(max_q(WIDTH));
    localparam logic signed [WIDTH-1:0] T_LIM  = WIDTH'(T_MIN);

    state_e                   r_state;
    logic [CW-1:0]            r_cnt;
    logic signed [WIDTH-1:0]  r_ox, r_oy, r_oz, r_cx, r_cy, r_cz;
    logic signed [WIDTH-1:0]  r_dx, r_dy, r_dz, r_radius;
    logic signed [LW-1:0]     r_lx, r_ly, r_lz;
    logic signed [AW-1:0]     r_ld, r_ll;
    logic signed [WIDTH-1:0]  r_tca;
    logic                     r_miss;
    logic [2*WIDTH-1:0]       r_sq_op;
    logic                     r_hit;
    logic [WIDTH-1:0]         r_t;

    logic signed [LW-1:0]     w_l;
    logic signed [WIDTH-1:0]  w_d;
    logic signed [AW-1:0]     w_l_ext, w_d_ext, w_ld_nx, w_ll_nx;
    logic signed [WIDTH-1:0]  w_tca;
    logic signed [HW-1:0]     w_tca_h, w_tca_sq, w_rad_h, w_r2, w_d2, w_h;
    logic                     w_rad_pos;
    logic                     w_miss;
    logic [2*WIDTH-1:0]       w_sq_op;
    logic                     w_sq_start, w_sq_busy, w_sq_done;
    logic [WIDTH-1:0]         w_sq_root;
    logic [WIDTH-1:0]         w_thc;
    logic signed [LW-1:0]     w_t0_w, w_t1_w;
    logic signed [WIDTH-1:0]  w_t0, w_t1;

    always_comb begin
        w_l = r_lz;
        w_d = r_dz;
        case (r_cnt)
            CW'(0): begin
                w_l = r_lx;
                w_d = r_dx;
            end
            CW'(1): begin
                w_l = r_ly;
                w_d = r_dy;
            end
            default: ;
        endcase
    end

    assign w_l_ext = AW'(w_l);
    assign w_d_ext = AW'(w_d);
    assign w_ld_nx = r_ld + w_l_ext * w_d_ext;
    assign w_ll_nx = r_ll + w_l_ext * w_l_ext;

    // Everything below stays at 2^-8 scale so h feeds the sqrt with no rescaling.
    assign w_tca     = WIDTH'(sat_to_width(32'(r_ld >>> Q_FRAC), WIDTH));
    assign w_tca_h   = HW'(w_tca);
    assign w_tca_sq  = w_tca_h * w_tca_h;
    assign w_rad_h   = HW'(r_radius);
    assign w_rad_pos = (r_radius > 0);
    assign w_r2      = w_rad_pos ? (w_rad_h * w_rad_h) : '0;
    assign w_d2      = HW'(r_ll) - w_tca_sq;
    assign w_h       = w_r2 - w_d2;
    assign w_miss    = w_h[HW-1] || !w_rad_pos;
    assign w_sq_op   = w_miss ? '0 : ((|w_h[HW-1:2*WIDTH]) ? '1 : w_h[2*WIDTH-1:0]);

    assign w_sq_start = (r_state == SQRT) && !w_sq_busy;

    seq_isqrt #(
        .WIDTH (WIDTH)
    ) u_isqrt (
        .clk     (clk),
        .rst     (rst),
        .start   (w_sq_start),
        .operand (r_sq_op),
        .busy    (w_sq_busy),
        .done    (w_sq_done),
        .root    (w_sq_root)
    );

    assign w_thc  = w_sq_root[WIDTH-1] ? T_MISS : w_sq_root;
    assign w_t0_w = {r_tca[WIDTH-1], r_tca} - {1'b0, w_thc};
    assign w_t1_w = {r_tca[WIDTH-1], r_tca} + {1'b0, w_thc};
    assign w_t0   = WIDTH'(sat_to_width(32'(w_t0_w), WIDTH));
    assign w_t1   = WIDTH'(sat_to_width(32'(w_t1_w), WIDTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_ox     <= '0;
            r_oy     <= '0;
            r_oz     <= '0;
            r_cx     <= '0;
            r_cy     <= '0;
            r_cz     <= '0;
            r_dx     <= '0;
            r_dy     <= '0;
            r_dz     <= '0;
            r_radius <= '0;
            r_lx     <= '0;
            r_ly     <= '0;
            r_lz     <= '0;
            r_ld     <= '0;
            r_ll     <= '0;
            r_tca    <= '0;
            r_miss   <= 1'b0;
            r_sq_op  <= '0;
            r_hit    <= 1'b0;
            r_t      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_ox     <= ox;
                        r_oy     <= oy;
                        r_oz     <= oz;
                        r_cx     <= cx;
                        r_cy     <= cy;
                        r_cz     <= cz;
                        r_dx     <= dx;
                        r_dy     <= dy;
                        r_dz     <= dz;
                        r_radius <= radius;
                        r_ld     <= '0;
                        r_ll     <= '0;
                        r_state  <= SUB;
                    end
                end
                SUB: begin
                    r_lx    <= {r_cx[WIDTH-1], r_cx} - {r_ox[WIDTH-1], r_ox};
                    r_ly    <= {r_cy[WIDTH-1], r_cy} - {r_oy[WIDTH-1], r_oy};
                    r_lz    <= {r_cz[WIDTH-1], r_cz} - {r_oz[WIDTH-1], r_oz};
                    r_cnt   <= '0;
                    r_state <= MAC;
                end
                MAC: begin
                    r_ld <= w_ld_nx;
                    r_ll <= w_ll_nx;
                    if (r_cnt == CW'(2)) begin
                        r_cnt   <= '0;
                        r_state <= TCA;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                TCA: begin
                    r_tca   <= w_tca;
                    r_miss  <= w_miss;
                    r_sq_op <= w_sq_op;
                    r_cnt   <= '0;
                    r_state <= SQRT;
                end
                SQRT: begin
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_state <= ROOT;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ROOT: begin
                    if (w_sq_done) begin
                        if (r_miss) begin
                            r_hit <= 1'b0;
                            r_t   <= T_MISS;
                        end else if (w_t0 >= T_LIM) begin
                            r_hit <= 1'b1;
                            r_t   <= w_t0;
                        end else if (w_t1 >= T_LIM) begin
                            r_hit <= 1'b1;
                            r_t   <= w_t1;
                        end else begin
                            r_hit <= 1'b0;
                            r_t   <= T_MISS;
                        end
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE) && !rst;
    assign out_valid = (r_state == DONE);
    assign out_hit   = r_hit;
    assign out_t     = r_t;

endmodule

// File: tb/tb_ray_sphere_intersect.sv
// Directed and randomized checks of ray_sphere_intersect against a plain-arithmetic model.
module tb_ray_sphere_intersect;

    localparam int W   = 12;
    localparam int LAT = 18;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] ox = '0, oy = '0, oz = '0;
    logic [W-1:0] dx = '0, dy = '0, dz = '0;
    logic [W-1:0] cx = '0, cy = '0, cz = '0;
    logic [W-1:0] radius = '0;
    logic         in_ready, out_valid, out_hit;
    logic [W-1:0] out_t;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ray_sphere_intersect #(
        .WIDTH (W),
        .T_MIN (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ox        (ox),
        .oy        (oy),
        .oz        (oz),
        .dx        (dx),
        .dy        (dy),
        .dz        (dz),
        .cx        (cx),
        .cy        (cy),
        .cz        (cz),
        .radius    (radius),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_hit   (out_hit),
        .out_t     (out_t)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sat_w(input longint x);
        if (x > 2047) return 2047;
        if (x < -2048) return -2048;
        return int'(x);
    endfunction

    function automatic int floor_sqrt(input longint x);
        longint lo = 0;
        longint hi = 4096;
        longint mid;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mid * mid <= x) lo = mid;
            else hi = mid;
        end
        return int'(lo);
    endfunction

    // Geometric reference: project L onto D, compare perpendicular distance with the radius.
    task automatic ref_model(input int a_ox, a_oy, a_oz, a_dx, a_dy, a_dz, a_cx, a_cy, a_cz,
                             a_r, output int e_hit, output int e_t);
        longint lx, ly, lz, ld, ll, d2, r2, h, op;
        int tca, thc, t0, t1;
        bit miss;
        lx = a_cx - a_ox;
        ly = a_cy - a_oy;
        lz = a_cz - a_oz;
        ld = lx * a_dx + ly * a_dy + lz * a_dz;
        ll = lx * lx + ly * ly + lz * lz;
        tca = sat_w(ld >>> 4);
        d2 = ll - longint'(tca) * tca;
        r2 = (a_r > 0) ? longint'(a_r) * a_r : 0;
        h = r2 - d2;
        miss = (h < 0) || (a_r <= 0);
        op = miss ? 0 : ((h > 16777215) ? 16777215 : h);
        thc = floor_sqrt(op);
        if (thc > 2047) thc = 2047;
        t0 = sat_w(longint'(tca) - thc);
        t1 = sat_w(longint'(tca) + thc);
        if (miss) begin
            e_hit = 0; e_t = 2047;
        end else if (t0 >= 1) begin
            e_hit = 1; e_t = t0;
        end else if (t1 >= 1) begin
            e_hit = 1; e_t = t1;
        end else begin
            e_hit = 0; e_t = 2047;
        end
    endtask

    task automatic drive(input int a_ox, a_oy, a_oz, a_dx, a_dy, a_dz, a_cx, a_cy, a_cz, a_r);
        ox = W'(a_ox); oy = W'(a_oy); oz = W'(a_oz);
        dx = W'(a_dx); dy = W'(a_dy); dz = W'(a_dz);
        cx = W'(a_cx); cy = W'(a_cy); cz = W'(a_cz);
        radius = W'(a_r);
    endtask

    task automatic scramble();
        drive($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
              $urandom, $urandom);
    endtask

    task automatic send(input int a_ox, a_oy, a_oz, a_dx, a_dy, a_dz, a_cx, a_cy, a_cz, a_r);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("accept_timeout", 32'(in_ready), 32'd1);
        drive(a_ox, a_oy, a_oz, a_dx, a_dy, a_dz, a_cx, a_cy, a_cz, a_r);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        scramble();
    endtask

    task automatic wait_valid(input string tag);
        int lat = 0;
        bit seen = 0;
        while (!seen && lat < 60) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check({tag, "_latency"}, 32'(lat), 32'(LAT));
    endtask

    task automatic check_out(input string tag, input int e_hit, input int e_t);
        check({tag, "_hit"}, 32'(out_hit), 32'(e_hit));
        check({tag, "_t"}, 32'(out_t), 32'(e_t & 32'hFFF));
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    task automatic expect_result(input string tag, input int e_hit, input int e_t);
        wait_valid(tag);
        check_out(tag, e_hit, e_t);
        release_out(tag);
    endtask

    initial begin
        int e_hit, e_t, n;
        int r_ox, r_oy, r_oz, r_dx, r_dy, r_dz, r_cx, r_cy, r_cz, r_r;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_hit", 32'(out_hit), 32'd0);
        check("rst_out_t", 32'(out_t), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rel_in_ready", 32'(in_ready), 32'd1);

        // Directed geometry cases
        send(0, 0, 0, 0, 0, 16, 0, 0, 160, 32);
        expect_result("hit_front", 1, 128);
        send(0, 0, 0, 0, 0, 16, 80, 0, 160, 32);
        expect_result("lateral_miss", 0, 2047);
        send(0, 0, 0, 0, 0, 16, 0, 0, 0, 32);
        expect_result("origin_inside", 1, 32);
        send(0, 0, 0, 0, 0, 16, 0, 0, -160, 32);
        expect_result("behind", 0, 2047);
        send(0, 0, 0, 0, 0, 16, 0, 0, 160, 0);
        expect_result("radius_zero", 0, 2047);
        send(0, 0, 0, 0, 0, 16, 0, 0, 160, -16);
        expect_result("radius_neg", 0, 2047);

        // Backpressure: result held while a competing request is offered
        send(0, 0, 0, 0, 0, 16, 0, 0, 160, 32);
        wait_valid("hold");
        drive(0, 0, 0, 0, 0, 16, 80, 0, 160, 32);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check_out("hold", 1, 128);
        end
        in_valid = 1'b0;
        release_out("hold");
        n = 0;
        repeat (3) begin
            @(negedge clk);
            if (!in_ready) n++;
        end
        check("hold_not_accepted", 32'(n), 32'd0);

        // Back-to-back requests, each issued as soon as the unit is idle
        send(16, 0, 0, 16, 0, 0, 200, 0, 0, 48);
        expect_result("b2b_x", 1, 136);
        send(0, 0, 0, 0, -16, 0, 0, -96, 0, 16);
        expect_result("b2b_negy", 1, 80);
        send(0, 0, 0, 0, 0, 16, 0, 0, 0, 32);
        expect_result("b2b_inside", 1, 32);

        // Randomized vectors against the reference model
        for (int i = 0; i < 40; i++) begin
            r_ox = int'($urandom_range(0, 128)) - 64;
            r_oy = int'($urandom_range(0, 128)) - 64;
            r_oz = int'($urandom_range(0, 128)) - 64;
            if ((i % 2) == 0) begin
                r_dx = 0; r_dy = 0; r_dz = 0;
                case ($urandom_range(0, 2))
                    0: r_dx = ($urandom_range(0, 1) != 0) ? 16 : -16;
                    1: r_dy = ($urandom_range(0, 1) != 0) ? 16 : -16;
                    default: r_dz = ($urandom_range(0, 1) != 0) ? 16 : -16;
                endcase
            end else begin
                r_dx = int'($urandom_range(0, 32)) - 16;
                r_dy = int'($urandom_range(0, 32)) - 16;
                r_dz = int'($urandom_range(0, 32)) - 16;
            end
            r_cx = int'($urandom_range(0, 800)) - 400;
            r_cy = int'($urandom_range(0, 800)) - 400;
            r_cz = int'($urandom_range(0, 800)) - 400;
            r_r  = int'($urandom_range(0, 332)) - 32;
            ref_model(r_ox, r_oy, r_oz, r_dx, r_dy, r_dz, r_cx, r_cy, r_cz, r_r, e_hit, e_t);
            // Early out_ready must not shift the result timing
            if ((i % 4) == 3) out_ready = 1'b1;
            send(r_ox, r_oy, r_oz, r_dx, r_dy, r_dz, r_cx, r_cy, r_cz, r_r);
            expect_result($sformatf("rand%0d", i), e_hit, e_t);
        end

        // Reset during SQRT: leave a nonzero result on the outputs first
        send(0, 0, 0, 0, 0, 16, 0, 0, 0, 32);
        expect_result("pre_rst", 1, 32);
        send(0, 0, 0, 0, 0, 16, 0, 0, 160, 32);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_hit", 32'(out_hit), 32'd0);
        check("midrst_t", 32'(out_t), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        n = 0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        check("midrst_no_result", 32'(n), 32'd0);
        check("midrst_ready_after", 32'(in_ready), 32'd1);
        send(0, 0, 0, 0, 0, 16, 0, 0, 160, 32);
        expect_result("post_rst", 1, 128);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ray_sphere_intersect.md
# ray_sphere_intersect

Multi-cycle ray–sphere intersection unit operating on Q8.4 fixed-point vectors. It accepts one ray and one sphere through a valid/ready handshake. It returns the nearest positive hit distance `t` or a miss after a fixed latency. It sits directly downstream of the vector-normalize stage, which supplies the unit-length ray direction, and upstream of shading.

## Interface
- `WIDTH`, 12: signed Q8.4 word width (4 fractional bits).
- `T_MIN`, 1: minimum accepted hit distance, raw Q8.4 (1/16). Suppresses self-intersection.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `in_valid` in 1: request present.
- `in_ready` out 1: unit can accept a request.
- `ox, oy, oz` in WIDTH each: ray origin, signed Q8.4.
- `dx, dy, dz` in WIDTH each: ray direction, signed Q8.4, expected normalized.
- `cx, cy, cz` in WIDTH each: sphere centre, signed Q8.4.
- `radius` in WIDTH: sphere radius, signed Q8.4.
- `out_valid` out 1: result present.
- `out_ready` in 1: consumer accepts result.
- `out_hit` out 1: 1 = intersection found.
- `out_t` out WIDTH: hit distance, Q8.4. Equals MAX_Q (0x7FF) on miss.

## Operation
FSM states and transitions:
- IDLE: `in_ready`=1. On `in_valid & in_ready`, all inputs are registered and the FSM goes to SUB.
- SUB: computes L = C − O per axis in WIDTH+1 bits, with no wrap. Goes to MAC.
- MAC: runs for 3 cycles, one axis per cycle (x, y, z).
  - Two multipliers accumulate LD += L·D and LL += L·L.
  - Products are full precision, scale 2^-8.
  - Accumulators are 2·WIDTH+4 bits signed.
- TCA: runs for 1 cycle.
  - tca = saturate_WIDTH(LD >>> 4).
  - d2 = LL − tca·tca.
  - r2 = radius·radius, forced to 0 when radius ≤ 0.
  - h = r2 − d2, all at 2^-8 scale.
  - miss_flag = (h < 0) or (radius ≤ 0).
  - The sqrt operand is h clamped to [0, 2^(2·WIDTH)−1]; it is 0 when miss_flag is set.
- SQRT: runs for WIDTH cycles. Restoring integer square root, one result bit per cycle, MSB first. The result is thc in Q8.4, since sqrt(x·2^8) = sqrt(x)·2^4. A result above MAX_Q saturates to MAX_Q.
- ROOT: runs for 1 cycle.
  - t0 = tca − thc and t1 = tca + thc, in WIDTH+1 bits, each saturated to WIDTH.
  - If miss_flag: hit=0, t=MAX_Q.
  - Else if t0 ≥ T_MIN: hit=1, t=t0.
  - Else if t1 ≥ T_MIN: hit=1, t=t1 (origin inside the sphere).
  - Else: hit=0, t=MAX_Q.
  - Goes to DONE.
- DONE: `out_valid`=1 with `out_hit` and `out_t` held stable. On `out_ready`, the FSM goes to IDLE.

SQRT always runs its full WIDTH cycles, including on a miss. This keeps latency fixed.

## Timing
- Reset values: `in_ready`=0 while `rst` is high and 1 in the first cycle after release. `out_valid`=0, `out_hit`=0, `out_t`=0. FSM is in IDLE. Accumulators and sqrt state are 0.
- Latency: if a request is accepted at edge N, `out_valid` rises after edge N+6+WIDTH (N+18 at default). This is fixed and independent of the data.
- `in_ready` is high only in IDLE. No request is accepted while busy or in DONE. Throughput is at most one ray per 8+WIDTH cycles.
- `out_valid` stays high and the outputs stay stable until `out_ready` is sampled high. Backpressure may last indefinitely.
- `out_ready` asserted before `out_valid` has no effect.
- On the handshake edge in DONE, `out_valid` drops and `in_ready` rises in the next cycle. There is no bypass from DONE to SUB.
- `rst` asserted in any state immediately returns the block to reset values. An in-flight request is discarded and no result is emitted.
- Input ports are sampled only on the accept edge. Changes afterwards are ignored.

## Structure
- Shared package `rayforge_pkg` holds:
  - Q_FRAC=4
  - MAX_Q and MIN_Q as functions of WIDTH
  - the state enum (IDLE, SUB, MAC, TCA, SQRT, ROOT, DONE)
  - a `sat_to_width` function reused by the other fixed-point stages.
- Sub-module `seq_isqrt`: iterative 2·WIDTH-bit to WIDTH-bit restoring square root.
  - Ports: `start`, `operand`, `busy`, `done`, `root`.
  - Clocked on `clk`, reset by `rst`.
  - Takes exactly WIDTH cycles from `start` to `done`.
- The top level holds the FSM, MAC datapath and root selection.

## Test plan
- **Hit in front.** O=(0,0,0), D=(0,0,16), C=(0,0,160), radius=32 -> tca=160, h=1024, thc=32. Expect `out_hit`=1, `out_t`=128 (8.0), exactly 18 cycles after accept.
- **Lateral miss.** C=(80,0,160), others as in the hit-in-front case -> d2=6400 > r2=1024. Expect `out_hit`=0, `out_t`=0x7FF, same latency.
- **Origin inside.** C=(0,0,0), radius=32, D=(0,0,16) -> t0=−32, t1=32. Expect `out_hit`=1, `out_t`=32.
- **Sphere behind / degenerate radius.**
  - C=(0,0,−160), radius=32 -> both roots negative. Expect `out_hit`=0, `out_t`=0x7FF.
  - radius=0 or −16 -> expect a miss.
- **Handshake.**
  - Hold `out_ready`=0 for 5 cycles after `out_valid` -> outputs stable, `in_ready`=0, and an `in_valid` presented meanwhile is not accepted.
  - Then release `out_ready` and issue back-to-back requests -> each result appears in order at the fixed latency.
- **Reset mid-operation.**
  - Assert `rst` during SQRT -> all outputs are 0 immediately and no `out_valid` pulse appears.
  - After release, `in_ready`=1 and the hit-in-front request gives `out_t`=128.
